ul_bank_reader: RTL

UL_BANK_READER -- requirements
Module: ul_bank_reader

---
 rtl/ul_bank_reader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ul_bank_reader.sv
// ul_bank_reader: sends the link-up acknowledge frame, then reads full ping-pong banks round-robin and packs decoded bytes into transmit words
module ul_bank_reader #(
  parameter int NBANK = 2,
  parameter int BANK_AW = 9,
  parameter int FRAME_LEN = 262,
  parameter int OUT_BYTES = 2,
  parameter int ACK_WORDS = 132,
  parameter int DONE_HOLD = 6,
  localparam int TW = 8 * OUT_BYTES,
  localparam int BW = $clog2(NBANK),
  localparam int AW = BANK_AW + BW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             link_en,
  input  logic             bus_busy,
  input  logic             word_done,
  input  logic [7:0]       dec_data,
  input  logic             dec_valid,
  input  logic [NBANK-1:0] bank_full,
  output logic [NBANK-1:0] bank_done,
  output logic             ram_rd_en,
  output logic [AW-1:0]    ram_rd_addr,
  output logic             dec_in_valid,
  output logic             dec_frame,
  output logic [TW-1:0]    tx_data,
  output logic             tx_req,
  output logic [15:0]      frame_cnt
);
  localparam int OW = BANK_AW + 1;
  localparam int IW = $clog2(OUT_BYTES + 1);
  localparam int KW = $clog2(ACK_WORDS + 1);
  localparam int HW = $clog2(DONE_HOLD + 1);
  localparam logic [OW-1:0] FL = OW'(FRAME_LEN);
  localparam logic [OW-1:0] OB = OW'(OUT_BYTES);
  localparam logic [IW-1:0] IB = IW'(OUT_BYTES);
  localparam logic [IW-1:0] IB1 = IW'(OUT_BYTES - 1);
  localparam logic [KW-1:0] KA = KW'(ACK_WORDS);
  localparam logic [HW-1:0] HD1 = HW'(DONE_HOLD - 1);
  typedef enum logic [1:0] {IDLE, ACK, READ, DONE} state_t;
  state_t state, state_nx;
  logic ack_sent, busy_w, sel_ok, wd;
  logic [BW-1:0] rr_ptr, cur_bank, sel;
  logic [OW-1:0] offset;
  logic [IW-1:0] iss, pk_cnt;
  logic [KW-1:0] k;
  logic [HW-1:0] hold;
  logic [TW-1:0] pk, ack_word;
  logic [BANK_AW-1:0] rd_off;
  function automatic logic [BW-1:0] wrap(input logic [BW-1:0] b, input int i);
    int j;
    j = int'(b) + i;
    return BW'(j >= NBANK ? j - NBANK : j);
  endfunction
  assign wd = word_done && busy_w;
  assign rd_off = BANK_AW'(offset + OW'(iss));
  always_comb
    ack_word = k == KW'(0) ? TW'(16'h4747) :
               k == KW'(1) ? TW'(16'h0F00) :
               k == KW'(2) ? TW'(16'h55AA) :
               k == KW'(3) ? TW'(16'h00FF) :
               k == KW'(4) ? TW'(16'h0100) : '0;
  always_comb begin
    sel = '0;
    sel_ok = 1'b0;
    for (int i = NBANK - 1; i >= 0; i--)
      if (bank_full[wrap(rr_ptr, i)]) begin
        sel = wrap(rr_ptr, i);
        sel_ok = 1'b1;
      end
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = !link_en ? IDLE :
               state == IDLE ? (!ack_sent ? ACK : (!bus_busy && sel_ok) ? READ : IDLE) :
               state == ACK  ? ((k == KA && !bus_busy) ? IDLE : ACK) :
               state == READ ? ((offset == FL && !bus_busy) ? DONE : READ) :
               (hold == HD1 ? IDLE : DONE);
  always_comb begin
    bank_done = '0;
    if (state == DONE) bank_done[cur_bank] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sent <= 1'b0;
      busy_w <= 1'b0;
      rr_ptr <= '0;
      cur_bank <= '0;
      offset <= '0;
      iss <= '0;
      pk_cnt <= '0;
      pk <= '0;
      k <= '0;
      hold <= '0;
      frame_cnt <= '0;
      tx_data <= '0;
      tx_req <= 1'b0;
      ram_rd_en <= 1'b0;
      ram_rd_addr <= '0;
      dec_in_valid <= 1'b0;
      dec_frame <= 1'b0;
    end else begin
      tx_req <= 1'b0;
      ram_rd_en <= 1'b0;
      dec_in_valid <= ram_rd_en;
      dec_frame <= state == READ && link_en;
      if (wd) busy_w <= 1'b0;
      if (!link_en) begin
        ack_sent <= 1'b0;
        busy_w <= 1'b0;
        iss <= '0;
        pk_cnt <= '0;
      end else if (state == IDLE) begin
        k <= '0;
        hold <= '0;
        offset <= '0;
        iss <= '0;
        pk_cnt <= '0;
        busy_w <= 1'b0;
        cur_bank <= sel;
      end else if (state == ACK) begin
        if (!busy_w && !bus_busy && k != KA) begin
          tx_data <= ack_word;
          tx_req <= 1'b1;
          busy_w <= 1'b1;
        end
        if (wd) k <= k + 1'b1;
        if (state_nx == IDLE) ack_sent <= 1'b1;
      end else if (state == READ) begin
        if (iss != IB && offset != FL) begin
          ram_rd_en <= 1'b1;
          ram_rd_addr <= {cur_bank, rd_off};
          iss <= iss + 1'b1;
        end
        if (wd && iss == IB) begin
          offset <= offset + OB;
          iss <= '0;
        end
        if (dec_valid) begin
          pk <= TW'({pk, dec_data});
          pk_cnt <= pk_cnt == IB1 ? '0 : pk_cnt + 1'b1;
          if (pk_cnt == IB1) begin
            tx_data <= TW'({pk, dec_data});
            tx_req <= 1'b1;
            busy_w <= 1'b1;
          end
        end
      end else begin
        hold <= hold + 1'b1;
        if (state_nx == IDLE) begin
          rr_ptr <= wrap(cur_bank, 1);
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end
endmodule
